demux_rr_dispatcher: RTL and testbench
======================================

// Module: demux_rr_dispatcher
// PURPOSE
//  Sequencer for the 1-to-8 demultiplexer datapath. Accepts a valid/ready word stream
//  and dispatches each word to one of 8 output channels, round-robin, skipping channels
//  that are masked or not ready. Drives the demux select/enable lines and a one-entry
//  hold register. Sits between a single producer and 8 channel consumers.
// PARAMETERS
//  DW       8    data word width
//  TIMEOUT  16   max cycles a word may wait in HOLD before it is dropped (1..255)
// PORTS
//  clk        in   1   rising-edge clock; single clock domain
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   producer word valid
//  in_data    in   DW  producer word
//  in_ready   out  1   dispatcher can capture in_data this cycle
//  ch_mask    in   8   1 = channel i eligible; sampled at capture only
//  ch_ready   in   8   per-channel consumer ready
//  sel        out  3   binary index of the channel being driven (demux select)
//  enable     out  1   demux enable; high only while a word is held
//  out_data   out  DW  held word, broadcast; qualified by enable/sel
//  ch_valid   out  8   one-hot valid to channel sel; all-zero when empty
//  drop       out  1   one-cycle pulse when a held word times out
//  word_cnt   out  16  count of words delivered; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=EMPTY, rr_ptr=0, sel=0, enable=0, ch_valid=0,
//   out_data=0, drop=0, word_cnt=0, wait counter=0. A held word is discarded.
//  States: EMPTY (no word), HOLD (word registered, waiting on ch_ready[sel]).
//  Pick: pick_hit / pick_idx = first i scanning rr_ptr, rr_ptr+1, ... mod 8 with
//   ch_mask[i] & ch_ready[i]. Combinational; computed every cycle.
//  deliver = (state==HOLD) & ch_ready[sel].
//  in_ready = pick_hit & ((state==EMPTY) | deliver). Combinational from ch_ready/ch_mask.
//  Capture (in_valid & in_ready): next cycle state=HOLD, out_data=in_data, sel=pick_idx,
//   enable=1, ch_valid=1<<pick_idx, wait=0, rr_ptr=pick_idx+1 (3-bit wrap 7->0).
//  In HOLD, sel/out_data/ch_valid remain stable until deliver or drop.
//  deliver: word_cnt+=1; with no capture in the same cycle -> EMPTY, enable=0, ch_valid=0.
//   Deliver and capture in the same cycle: back-to-back, state stays HOLD with new word.
//   Zero bubble; 1 word/cycle sustained.
//  Timeout: in HOLD without deliver, wait+=1; when wait==TIMEOUT-1 and no deliver ->
//   drop=1 for one cycle, state=EMPTY, word_cnt unchanged. rr_ptr is unchanged
//   (already advanced). deliver on the timeout cycle wins over drop.
//  Latency: capture to ch_valid = 1 cycle. No combinational in_data->out_data path.
//  Boundaries:
//   - All channels masked or not ready: pick_hit=0, in_ready=0, producer stalls.
//   - ch_ready[sel] drops after capture: word waits; no re-steer to another channel.
//   - Wrap: rr_ptr=7 with channel 7 picked -> rr_ptr=0.
//   - ch_mask change during HOLD: ignored for the held word.
//   - in_valid low: no state change except HOLD deliver/timeout.
//   - Widths: wait counter is 8 bits; word_cnt is modulo 2^16.
// STRUCTURE
//  demux_defs.vh: N_CH=8, SEL_W=3, state encodings ST_EMPTY=1'b0, ST_HOLD=1'b1.
//  Sub-module demux_rr_pick (combinational): inputs req[7:0], ptr[2:0]; outputs hit,
//   idx[2:0]. Rotate-priority finder. Top holds the FSM, registers, and counters.
// TESTING
//  1 All ch_mask/ch_ready=8'hFF, 10 words 0x01..0x0A back-to-back -> sel 0,1..7,0,1;
//    in_ready stays 1; word_cnt=10; no bubbles.
//  2 ch_mask=8'b1010_0100, ready all 1 -> words go to ch 2,5,7,2,5... only.
//  3 ch_ready=0 all, in_valid=1 -> in_ready=0, enable=0 indefinitely. Raise ch_ready[3]
//    -> capture next cycle, sel=3, ch_valid=8'h08.
//  4 Capture to ch 4, then drop ch_ready[4] -> drop pulses at cycle TIMEOUT after capture,
//    word_cnt unchanged. Next word goes to ch 5.
//  5 Deliver on exactly the TIMEOUT-1 wait cycle -> no drop, word_cnt+1.
//  6 Assert rst_n=0 mid-HOLD (asynchronously, between edges) -> enable/ch_valid/word_cnt=0
//    immediately. After release, the first word goes to ch 0.

Source files
------------

// File: rtl/demux_rr_dispatcher_pkg.sv
// ============================================================================
// demux_rr_dispatcher_pkg : shared constants and FSM encoding for the dispatcher
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_rr_dispatcher_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/demux_rr_dispatcher_pick.sv
// ============================================================================
// demux_rr_pick : rotate-priority finder, first set req bit at or after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_rr_pick
  import demux_rr_dispatcher_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Scan farthest offset first so the closest request to ptr wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_rr_dispatcher.sv
// ============================================================================
// demux_rr_dispatcher : round-robin 1-to-8 word dispatcher with hold/timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_rr_dispatcher
  import demux_rr_dispatcher_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [DW-1:0]    in_data_i,
  output logic             in_ready_o,
  input  logic [N_CH-1:0]  ch_mask_i,
  input  logic [N_CH-1:0]  ch_ready_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             enable_o,
  output logic [DW-1:0]    out_data_o,
  output logic [N_CH-1:0]  ch_valid_o,
  output logic             drop_o,
  output logic [15:0]      word_cnt_o
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [7:0]       wait_q, wait_d;
  logic             drop_q, drop_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             pick_hit;
  logic [SEL_W-1:0] pick_idx;
  logic             holding;
  logic             deliver;
  logic             capture;
  logic             timeout;

  demux_rr_pick u_pick (
    .req_i (ch_mask_i & ch_ready_i),
    .ptr_i (rr_ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign holding    = (state_q == ST_HOLD);
  assign deliver    = holding & ch_ready_i[sel_q];
  assign in_ready_o = pick_hit & (~holding | deliver);
  assign capture    = in_valid_i & in_ready_o;
  assign timeout    = holding & ~deliver & (wait_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    wait_d   = wait_q;
    drop_d   = 1'b0;
    cnt_d    = cnt_q;

    if (deliver) begin
      cnt_d = cnt_q + 16'd1;
    end

    // Capture in HOLD only happens alongside deliver, so the branches are exclusive.
    if (capture) begin
      state_d  = ST_HOLD;
      data_d   = in_data_i;
      sel_d    = pick_idx;
      wait_d   = 8'd0;
      rr_ptr_d = pick_idx + SEL_W'(1);
    end else if (deliver) begin
      state_d = ST_EMPTY;
    end else if (timeout) begin
      state_d = ST_EMPTY;
      drop_d  = 1'b1;
    end else if (holding) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      wait_q   <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      wait_q   <= wait_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
    end
  end

  // Decoded from registered state so async reset clears the channel lines at once.
  assign enable_o   = holding;
  assign ch_valid_o = holding ? (N_CH'(1) << sel_q) : '0;
  assign sel_o      = sel_q;
  assign out_data_o = data_q;
  assign drop_o     = drop_q;
  assign word_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
// ============================================================================
// tb_demux_rr_dispatcher : vector table, corner sequences and randomized model check
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux_rr_dispatcher;

  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  ch_mask;
  logic [7:0]  ch_ready;
  logic [2:0]  sel;
  logic        enable;
  logic [7:0]  out_data;
  logic [7:0]  ch_valid;
  logic        drop;
  logic [15:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  demux_rr_dispatcher #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .ch_mask_i  (ch_mask),
    .ch_ready_i (ch_ready),
    .sel_o      (sel),
    .enable_o   (enable),
    .out_data_o (out_data),
    .ch_valid_o (ch_valid),
    .drop_o     (drop),
    .word_cnt_o (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic [7:0]  mask;
    logic [7:0]  rdy;
    logic        e_ready;
    logic [2:0]  e_sel;
    logic        e_en;
    logic [7:0]  e_cv;
    logic [7:0]  e_dat;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] d, input logic [7:0] m, input logic [7:0] r);
    in_valid = v;
    in_data  = d;
    ch_mask  = m;
    ch_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word is either held for a channel or not; age counts HOLD cycles.
  bit         m_held;
  int         m_sel;
  logic [7:0] m_data;
  int         m_rr;
  int         m_age;
  int         m_cnt;
  bit         m_drop;

  function automatic int pick_ch(input logic [7:0] req, input int ptr);
    for (int off = 0; off < 8; off++) begin
      if (req[(ptr + off) % 8]) return (ptr + off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_sel = 0; m_data = 8'h00; m_rr = 0; m_age = 0; m_cnt = 0; m_drop = 0;
  endtask

  task automatic model_check_and_step();
    int  p;
    bit  dlv, rdy_exp, cap;
    p       = pick_ch(ch_mask & ch_ready, m_rr);
    dlv     = m_held && ch_ready[m_sel];
    rdy_exp = (p >= 0) && (!m_held || dlv);
    cap     = in_valid && rdy_exp;
    chk("rnd_in_ready", in_ready, rdy_exp);
    chk("rnd_enable",   enable,   m_held);
    chk("rnd_sel",      sel,      m_sel);
    chk("rnd_ch_valid", ch_valid, m_held ? (32'h1 << m_sel) : 32'h0);
    chk("rnd_out_data", out_data, m_data);
    chk("rnd_drop",     drop,     m_drop);
    chk("rnd_word_cnt", word_cnt, m_cnt);
    m_drop = 0;
    if (dlv) m_cnt = (m_cnt + 1) % 65536;
    if (cap) begin
      m_held = 1; m_sel = p; m_data = in_data; m_rr = (p + 1) % 8; m_age = 0;
    end else if (dlv) begin
      m_held = 0;
    end else if (m_held) begin
      if (m_age == TIMEOUT - 1) begin
        m_held = 0; m_drop = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic do_reset();
    apply(0, 8'h00, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    apply(0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    chk("rst_enable",   enable,   0);
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_sel",      sel,      0);
    chk("rst_out_data", out_data, 0);
    chk("rst_drop",     drop,     0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    #2 rst_n = 1'b1;
    tick();

    // Full rate, all channels
    tbl.push_back('{1'b1, 8'h01, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 16'd0});
    tbl.push_back('{1'b1, 8'h02, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1, 8'h01, 8'h01, 16'd0});
    tbl.push_back('{1'b1, 8'h03, 8'hFF, 8'hFF, 1'b1, 3'd1, 1'b1, 8'h02, 8'h02, 16'd1});
    tbl.push_back('{1'b1, 8'h04, 8'hFF, 8'hFF, 1'b1, 3'd2, 1'b1, 8'h04, 8'h03, 16'd2});
    tbl.push_back('{1'b1, 8'h05, 8'hFF, 8'hFF, 1'b1, 3'd3, 1'b1, 8'h08, 8'h04, 16'd3});
    tbl.push_back('{1'b1, 8'h06, 8'hFF, 8'hFF, 1'b1, 3'd4, 1'b1, 8'h10, 8'h05, 16'd4});
    tbl.push_back('{1'b1, 8'h07, 8'hFF, 8'hFF, 1'b1, 3'd5, 1'b1, 8'h20, 8'h06, 16'd5});
    tbl.push_back('{1'b1, 8'h08, 8'hFF, 8'hFF, 1'b1, 3'd6, 1'b1, 8'h40, 8'h07, 16'd6});
    tbl.push_back('{1'b1, 8'h09, 8'hFF, 8'hFF, 1'b1, 3'd7, 1'b1, 8'h80, 8'h08, 16'd7});
    tbl.push_back('{1'b1, 8'h0A, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1, 8'h01, 8'h09, 16'd8});
    tbl.push_back('{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 3'd1, 1'b1, 8'h02, 8'h0A, 16'd9});
    tbl.push_back('{1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 3'd1, 1'b0, 8'h00, 8'h0A, 16'd10});
    // Mask 1010_0100: only channels 2, 5, 7
    tbl.push_back('{1'b1, 8'h11, 8'hA4, 8'hFF, 1'b1, 3'd1, 1'b0, 8'h00, 8'h0A, 16'd10});
    tbl.push_back('{1'b1, 8'h12, 8'hA4, 8'hFF, 1'b1, 3'd2, 1'b1, 8'h04, 8'h11, 16'd10});
    tbl.push_back('{1'b1, 8'h13, 8'hA4, 8'hFF, 1'b1, 3'd5, 1'b1, 8'h20, 8'h12, 16'd11});
    tbl.push_back('{1'b1, 8'h14, 8'hA4, 8'hFF, 1'b1, 3'd7, 1'b1, 8'h80, 8'h13, 16'd12});
    tbl.push_back('{1'b1, 8'h15, 8'hA4, 8'hFF, 1'b1, 3'd2, 1'b1, 8'h04, 8'h14, 16'd13});
    tbl.push_back('{1'b0, 8'h00, 8'hA4, 8'hFF, 1'b1, 3'd5, 1'b1, 8'h20, 8'h15, 16'd14});
    tbl.push_back('{1'b0, 8'h00, 8'hA4, 8'hFF, 1'b1, 3'd5, 1'b0, 8'h00, 8'h15, 16'd15});
    // Nobody ready: stall, then channel 3 comes up
    tbl.push_back('{1'b1, 8'h33, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b0, 8'h00, 8'h15, 16'd15});
    tbl.push_back('{1'b1, 8'h33, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b0, 8'h00, 8'h15, 16'd15});
    tbl.push_back('{1'b1, 8'h33, 8'hFF, 8'h00, 1'b0, 3'd5, 1'b0, 8'h00, 8'h15, 16'd15});
    tbl.push_back('{1'b1, 8'h33, 8'hFF, 8'h08, 1'b1, 3'd5, 1'b0, 8'h00, 8'h15, 16'd15});
    tbl.push_back('{1'b0, 8'h00, 8'hFF, 8'h08, 1'b1, 3'd3, 1'b1, 8'h08, 8'h33, 16'd15});
    tbl.push_back('{1'b0, 8'h00, 8'hFF, 8'h08, 1'b1, 3'd3, 1'b0, 8'h00, 8'h33, 16'd16});

    foreach (tbl[i]) begin
      apply(tbl[i].vld, tbl[i].data, tbl[i].mask, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d_sel", i),      sel,      tbl[i].e_sel);
      chk($sformatf("vec%0d_enable", i),   enable,   tbl[i].e_en);
      chk($sformatf("vec%0d_ch_valid", i), ch_valid, tbl[i].e_cv);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_dat);
      chk($sformatf("vec%0d_word_cnt", i), word_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_drop", i),     drop,     0);
      tick();
    end

    // Timeout: word for channel 4 is dropped TIMEOUT cycles after capture
    apply(1, 8'h44, 8'hFF, 8'hFF);
    #1 chk("t4_in_ready", in_ready, 1);
    tick();
    chk("t4_sel", sel, 4);
    apply(0, 8'h00, 8'h00, 8'hEF);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("t4_hold_enable", enable, 1);
      chk("t4_hold_drop",   drop,   0);
    end
    tick();
    chk("t4_drop",     drop,     1);
    chk("t4_enable",   enable,   0);
    chk("t4_word_cnt", word_cnt, 16);
    apply(1, 8'h45, 8'hFF, 8'hFF);
    tick();
    chk("t4_drop_clear", drop, 0);
    chk("t4_next_sel",   sel,  5);
    chk("t4_next_cv",    ch_valid, 8'h20);
    apply(0, 8'h00, 8'hFF, 8'hFF);
    tick();
    chk("t4_next_cnt", word_cnt, 17);

    // Deliver on the last wait cycle beats the drop
    apply(1, 8'h55, 8'hFF, 8'hFF);
    tick();
    chk("t5_sel", sel, 6);
    apply(0, 8'h00, 8'hFF, 8'hBF);
    for (int k = 1; k < TIMEOUT; k++) tick();
    chk("t5_still_held", enable, 1);
    chk("t5_data_stable", out_data, 8'h55);
    apply(0, 8'h00, 8'hFF, 8'hFF);
    tick();
    chk("t5_no_drop",  drop,     0);
    chk("t5_enable",   enable,   0);
    chk("t5_word_cnt", word_cnt, 18);

    // Pointer wrap 7 -> 0, then asynchronous reset mid-HOLD
    apply(1, 8'h66, 8'hFF, 8'hFF);
    tick();
    chk("t6_sel7", sel, 7);
    apply(1, 8'h67, 8'hFF, 8'hFF);
    tick();
    chk("t6_wrap_sel", sel,      0);
    chk("t6_wrap_cv",  ch_valid, 8'h01);
    apply(0, 8'h00, 8'hFF, 8'h00);
    tick();
    chk("t6_held", enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_enable",   enable,   0);
    chk("t6_async_ch_valid", ch_valid, 0);
    chk("t6_async_word_cnt", word_cnt, 0);
    chk("t6_async_out_data", out_data, 0);
    #2 rst_n = 1'b1;
    tick();
    apply(1, 8'h77, 8'hFF, 8'hFF);
    #1 chk("t6_post_in_ready", in_ready, 1);
    tick();
    chk("t6_post_sel", sel,      0);
    chk("t6_post_cv",  ch_valid, 8'h01);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] m, r;
      m = (($urandom % 4) == 0) ? 8'(($urandom)) : 8'hFF;
      if (((c / 100) % 3) == 2) r = 8'($urandom & $urandom & $urandom);
      else                      r = 8'($urandom);
      apply(($urandom % 4) != 0, 8'($urandom), m, r);
      #1;
      model_check_and_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
